apb_rd_streamer: RTL

//  APB master (initiator) that reads Rd_Length consecutive 32-bit words from an APB slave, starting at Rd_Base.

---
 rtl/apb_rd_streamer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apb_rd_streamer.sv
// APB read master: fetches Rd_Length words from Rd_Base and emits them as one AXI-Stream packet.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.

module apb_rd_streamer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 12,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              S_APB_aclk,
  input  logic              S_APB_aresetn,
  input  logic              Rd_start,
  input  logic [ADDR_W-1:0] Rd_Base,
  input  logic [LEN_W-1:0]  Rd_Length,
  output logic              Rd_busy,
  output logic              Rd_done,
  output logic              Rd_err,
  output logic [ADDR_W-1:0] M_APB_paddr,
  output logic              M_APB_psel,
  output logic              M_APB_penable,
  output logic              M_APB_pwrite,
  output logic [DATA_W-1:0] M_APB_pwdata,
  input  logic [DATA_W-1:0] M_APB_prdata,
  input  logic              M_APB_pready,
  input  logic              M_APB_pslverr,
  output logic [DATA_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  output logic [3:0]        M_AXIS_tkeep,
  output logic              M_AXIS_tlast,
  input  logic              M_AXIS_tready
);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StPush, StDone} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic               r_start_s;
  logic               r_start_d;
  logic [ADDR_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_tdata;
  logic               r_last;
  logic               r_err;

  logic w_start_edge;
  logic w_accept;
  logic w_acc_done;
  logic w_acc_err;
  logic w_psel;
  logic w_penable;
  logic w_busy;
  logic w_done;
  logic w_tvalid;

  assign w_start_edge = r_start_s & ~r_start_d;
  assign w_accept     = (r_state == StIdle) && w_start_edge;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] r_tmo_cnt;
  logic            w_tmo;

  // Counts ACCESS cycles without pready; the last allowed cycle forces an error completion.
  assign w_tmo = (r_tmo_cnt == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StAccess && !M_APB_pready) begin
      r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_acc_done = M_APB_pready | w_tmo;
  assign w_acc_err  = M_APB_pready ? M_APB_pslverr : w_tmo;
`else
  assign w_acc_done = M_APB_pready;
  assign w_acc_err  = M_APB_pslverr;
`endif

  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      r_state   <= StIdle;
      r_start_s <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_start_s <= Rd_start;
      r_start_d <= r_start_s;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_tvalid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_state_d = (Rd_Length == '0) ? StDone : StSetup;
        end
      end
      StSetup: begin
        w_psel    = 1'b1;
        w_busy    = 1'b1;
        w_state_d = StAccess;
      end
      StAccess: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        w_busy    = 1'b1;
        if (w_acc_done) begin
          w_state_d = StPush;
        end
      end
      StPush: begin
        w_tvalid = 1'b1;
        w_busy   = 1'b1;
        if (M_AXIS_tready) begin
          w_state_d = r_last ? StDone : StSetup;
        end
      end
      StDone: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // r_last doubles as the "stop after this beat" flag for errored accesses.
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      r_base  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_tdata <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base <= Rd_Base;
        r_len  <= Rd_Length;
        r_idx  <= '0;
        r_err  <= 1'b0;
      end
      if (r_state == StAccess && w_acc_done) begin
        r_tdata <= w_acc_err ? '0 : M_APB_prdata;
        r_last  <= w_acc_err | (r_idx == r_len - LEN_W'(1));
        if (w_acc_err) begin
          r_err <= 1'b1;
        end
      end
      if (r_state == StPush && M_AXIS_tready && !r_last) begin
        r_idx <= r_idx + LEN_W'(1);
      end
    end
  end

  assign M_APB_paddr   = r_base + (ADDR_W'(r_idx) << 2);
  assign M_APB_psel    = w_psel;
  assign M_APB_penable = w_penable;
  assign M_APB_pwrite  = 1'b0;
  assign M_APB_pwdata  = '0;

  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tvalid = w_tvalid;
  assign M_AXIS_tkeep  = {4{w_tvalid}};
  assign M_AXIS_tlast  = w_tvalid & r_last;

  assign Rd_busy = w_busy;
  assign Rd_done = w_done;
  assign Rd_err  = r_err;

endmodule
